// File: rtl/kogge_stone_pipelined_adder_if.sv
// rtl/kogge_stone_pipelined_adder_if.sv - operand/result stream bundle for the prefix adder
interface kogge_stone_pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/kogge_stone_pipelined_adder.sv
// rtl/kogge_stone_pipelined_adder.sv - pipelined Kogge-Stone adder/subtractor with valid/ready
module kogge_stone_pipelined_adder #(
  parameter int WIDTH    = 16,
  parameter int PIPELINE = 1
) (
  input logic                       clk,
  input logic                       rst,
  kogge_stone_pipelined_adder_if.slave bus
);
  localparam int L = $clog2(WIDTH);

  // Everything a stage needs downstream: group G/P plus the original p and sign bits.
  typedef struct packed {
    logic             v;
    logic             c0;
    logic             a_msb;
    logic             be_msb;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gp;
    logic [WIDTH-1:0] g;
  } stage_t;

  function automatic stage_t prefix_level(input stage_t s, input int d);
    stage_t r;
    r    = s;
    r.g  = s.g | (s.gp & (s.g << d));
    r.gp = s.gp & ((s.gp << d) | ~({WIDTH{1'b1}} << d));
    return r;
  endfunction

  logic             en;
  logic [WIDTH-1:0] b_e;
  stage_t           pre;
  stage_t           stg [0:L];
  stage_t           lvl [0:L-1];
  logic [WIDTH-1:0] res;
  logic             res_cout;
  logic             res_ovf;

  // Whole pipeline advances together; bubbles are held, never squeezed out.
  assign en           = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = en;

  always_comb begin
    b_e        = bus.sub ? ~bus.b : bus.b;
    pre        = '0;
    pre.v      = bus.in_valid;
    pre.c0     = bus.sub | bus.cin;
    pre.a_msb  = bus.a[WIDTH-1];
    pre.be_msb = b_e[WIDTH-1];
    pre.p      = bus.a ^ b_e;
    pre.gp     = pre.p;
    pre.g      = bus.a & b_e;
    pre.g[0]   = pre.g[0] | (pre.p[0] & pre.c0);
  end

  for (genvar k = 0; k < L; k++) begin : g_level
    assign lvl[k] = prefix_level(stg[k], 1 << k);
  end

  if (PIPELINE != 0) begin : g_pipe
    stage_t q [0:L];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s <= L; s++) q[s] <= '0;
      end else if (en) begin
        q[0] <= pre;
        for (int s = 1; s <= L; s++) q[s] <= lvl[s-1];
      end
    end

    for (genvar s = 0; s <= L; s++) begin : g_tap
      assign stg[s] = q[s];
    end
  end else begin : g_flat
    assign stg[0] = pre;
    for (genvar s = 1; s <= L; s++) begin : g_tap
      assign stg[s] = lvl[s-1];
    end
  end

  assign res      = {stg[L].p[WIDTH-1:1] ^ stg[L].g[WIDTH-2:0], stg[L].p[0] ^ stg[L].c0};
  assign res_cout = stg[L].g[WIDTH-1];
  assign res_ovf  = (stg[L].a_msb == stg[L].be_msb) && (res[WIDTH-1] != stg[L].a_msb);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.sum       <= '0;
      bus.cout      <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.zero      <= 1'b0;
    end else if (en) begin
      bus.out_valid <= stg[L].v;
      if (stg[L].v) begin
        bus.sum  <= res;
        bus.cout <= res_cout;
        bus.ovf  <= res_ovf;
        bus.zero <= ~|res;
      end
    end
  end
endmodule
